// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the display overlay arbiter
//
// Purpose: arbiter state encoding, default segment bus width, named source
// indices matching the mode encodings, and a saturating counter helper.
// Ports: none (package).
package disp_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_BLANK   = 2'd1,
    ST_NORMAL  = 2'd2,
    ST_OVERLAY = 2'd3
  } disp_state_e;

  localparam int DIG_W_DEF = 8;

  localparam int SRC_TIME     = 0;
  localparam int SRC_CLEAN    = 4;
  localparam int SRC_ANNOUNCE = 5;
  localparam int SRC_GESTURE  = 6;
  localparam int SRC_CUMUL    = 7;

  // Blank and overlay counters stick at their maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/disp_overlay_arbiter_tick_gen.sv
// rtl/disp_overlay_arbiter_tick_gen.sv - overlay tick prescaler with half-period flag
//
// Purpose: counts clk cycles 0..DIV-1 while enabled and pulses tick on the
// last count; half is high during the second half of each period.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   clr  in   synchronous clear (wins over en)
//   en   in   count enable
//   tick out  one-cycle pulse when the count is DIV-1 and enabled
//   half out  count >= DIV/2
module tick_gen #(
  parameter int DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic half
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST  = W'(DIV - 1);
  localparam logic [W-1:0] HALFV = W'(DIV / 2);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);
  assign half = (cnt_q >= HALFV);

endmodule

// File: rtl/disp_overlay_arbiter.sv
// rtl/disp_overlay_arbiter.sv - seven-segment source selector with timed overlays
//
// Purpose: picks one of NSRC segment sources by mode_sel, shows timed overlay
// sources on request, inserts BLANK_CYC dark cycles on every source change and
// forces dark while power_on is low.
// Optional build macro DISP_OVERLAY_BLINK_EN: blanks tube_sel during the
// second half of every overlay tick period.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   power_on                      0 forces OFF and dark outputs
//   mode_sel                      normal source index
//   ovr_req, ovr_src, ovr_cancel  overlay request pulse/index, cancel pulse
//   src_digit1/2, src_tube_sel    packed sources, source i at [i*DIG_W +: DIG_W]
//   digit1, digit2, tube_sel      registered pin outputs
//   active_src                    index currently shown (0 when OFF)
//   ovr_active                    overlay shown or being blanked into
module disp_overlay_arbiter
  import disp_pkg::*;
#(
  parameter int NSRC      = 8,
  parameter int SEL_W     = 3,
  parameter int DIG_W     = DIG_W_DEF,
  parameter int TICK_DIV  = 100000000,
  parameter int OVR_SECS  = 5,
  parameter int BLANK_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_on,
  input  logic [SEL_W-1:0]      mode_sel,
  input  logic                  ovr_req,
  input  logic [SEL_W-1:0]      ovr_src,
  input  logic                  ovr_cancel,
  input  logic [NSRC*DIG_W-1:0] src_digit1,
  input  logic [NSRC*DIG_W-1:0] src_digit2,
  input  logic [NSRC*DIG_W-1:0] src_tube_sel,
  output logic [DIG_W-1:0]      digit1,
  output logic [DIG_W-1:0]      digit2,
  output logic [DIG_W-1:0]      tube_sel,
  output logic [SEL_W-1:0]      active_src,
  output logic                  ovr_active
);

`ifdef DISP_OVERLAY_BLINK_EN
  localparam logic BLINK_EN = 1'b1;
`else
  localparam logic BLINK_EN = 1'b0;
`endif

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
  localparam logic [7:0] OVR_LAST   = 8'(OVR_SECS - 1);

  disp_state_e      state_q, state_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic             to_ovr_q, to_ovr_d;
  logic [7:0]       blank_cnt_q, blank_cnt_d;
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;
  logic [DIG_W-1:0] d1_q, d1_d, d2_q, d2_d, ts_q, ts_d;

  logic             blank_go;
  logic [SEL_W-1:0] blank_tgt;
  logic             blank_ovr;
  logic             tick_clr, tick_en, tick, half;

  // Indices with no source behind them read as all-zero segments.
  function automatic logic [DIG_W-1:0] pick(input logic [NSRC*DIG_W-1:0] bus,
                                            input logic [SEL_W-1:0]      idx);
    logic [DIG_W-1:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (idx == SEL_W'(i)) r = bus[i*DIG_W +: DIG_W];
    end
    return r;
  endfunction

  // Prescaler only runs while an overlay is on screen, so the first tick
  // lands exactly TICK_DIV cycles after entering OVERLAY.
  assign tick_en = (state_q == ST_OVERLAY);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick),
    .half (half)
  );

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    target_d    = target_q;
    to_ovr_d    = to_ovr_q;
    blank_cnt_d = blank_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    blank_go    = 1'b0;
    blank_tgt   = mode_sel;
    blank_ovr   = 1'b0;
    tick_clr    = (state_q != ST_OVERLAY);

    unique case (state_q)
      ST_OFF: begin
        blank_go = power_on;
      end
      ST_BLANK: begin
        // Cancel only matters when an overlay is pending or the mode moved;
        // mode changes are ignored while blanking toward an overlay.
        if (ovr_cancel) begin
          blank_go = to_ovr_q || (mode_sel != target_q);
        end else if (ovr_req) begin
          blank_go  = 1'b1;
          blank_tgt = ovr_src;
          blank_ovr = 1'b1;
        end else begin
          blank_go = !to_ovr_q && (mode_sel != target_q);
        end
        if (!blank_go) begin
          if (blank_cnt_q >= BLANK_LAST) begin
            state_d   = to_ovr_q ? ST_OVERLAY : ST_NORMAL;
            active_d  = target_q;
            ovr_cnt_d = '0;
          end else begin
            blank_cnt_d = sat_inc8(blank_cnt_q);
          end
        end
      end
      ST_NORMAL: begin
        if (!ovr_cancel && ovr_req) begin
          blank_go  = 1'b1;
          blank_tgt = ovr_src;
          blank_ovr = 1'b1;
        end else begin
          blank_go = (mode_sel != active_q);
        end
      end
      ST_OVERLAY: begin
        if (ovr_cancel) begin
          blank_go = 1'b1;
        end else if (ovr_req && (ovr_src == active_q)) begin
          ovr_cnt_d = '0;
          tick_clr  = 1'b1;
        end else if (ovr_req) begin
          blank_go  = 1'b1;
          blank_tgt = ovr_src;
          blank_ovr = 1'b1;
        end else if (tick) begin
          if (ovr_cnt_q >= OVR_LAST) begin
            blank_go = 1'b1;
          end else begin
            ovr_cnt_d = sat_inc8(ovr_cnt_q);
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (blank_go) begin
      state_d     = ST_BLANK;
      target_d    = blank_tgt;
      to_ovr_d    = blank_ovr;
      blank_cnt_d = '0;
      ovr_cnt_d   = '0;
    end

    if (!power_on) begin
      state_d     = ST_OFF;
      active_d    = SEL_W'(SRC_TIME);
      target_d    = '0;
      to_ovr_d    = 1'b0;
      blank_cnt_d = '0;
      ovr_cnt_d   = '0;
    end
  end

  // Pins follow the current state one cycle later; power loss darkens them
  // on the very edge it is seen.
  always_comb begin
    d1_d = '0;
    d2_d = '0;
    ts_d = '0;
    if (power_on && (state_q == ST_NORMAL || state_q == ST_OVERLAY)) begin
      d1_d = pick(src_digit1, active_q);
      d2_d = pick(src_digit2, active_q);
      ts_d = pick(src_tube_sel, active_q);
      if (BLINK_EN && (state_q == ST_OVERLAY) && half) ts_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_OFF;
      active_q    <= SEL_W'(SRC_TIME);
      target_q    <= '0;
      to_ovr_q    <= 1'b0;
      blank_cnt_q <= '0;
      ovr_cnt_q   <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      ts_q        <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      target_q    <= target_d;
      to_ovr_q    <= to_ovr_d;
      blank_cnt_q <= blank_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      ts_q        <= ts_d;
    end
  end

  assign digit1     = d1_q;
  assign digit2     = d2_q;
  assign tube_sel   = ts_q;
  assign active_src = active_q;
  assign ovr_active = (state_q == ST_OVERLAY) || (state_q == ST_BLANK && to_ovr_q);

endmodule
